// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    REQ_IF,
    REQ_D
  } req_id_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_MEM_AW = 6;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational requester pick; fixed D > IF priority unless ARB_RR_EN selects round-robin.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    if_valid,
  input  logic    d_valid,
`ifdef ARB_RR_EN
  input  req_id_t rr_last,
`endif
  input  logic    window,
  output logic    if_ready,
  output logic    d_ready
);

  req_id_t pick;

  always_comb begin
    pick = REQ_D;
    if (if_valid && d_valid) begin
`ifdef ARB_RR_EN
      // On a tie the requester that did not win last time goes first.
      pick = (rr_last == REQ_D) ? REQ_IF : REQ_D;
`else
      pick = REQ_D;
`endif
    end else if (if_valid) begin
      pick = REQ_IF;
    end
  end

  assign if_ready = window && if_valid && (pick == REQ_IF);
  assign d_ready  = window && d_valid  && (pick == REQ_D);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Optional macro ARB_RR_EN switches tie-breaking from fixed D priority to round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MEM_AW = DEF_MEM_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [DATA_W-1:0] if_req_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [DATA_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_reg, state_next;
  req_id_t           owner_reg, owner_next;
  logic [DATA_W-1:0] if_data_reg, if_data_next;
  logic [DATA_W-1:0] d_data_reg, d_data_next;
  logic [MEM_AW-1:0] mem_addr_reg, mem_addr_next;
  logic              grant_window, if_acc, d_acc;

  // Byte offset and bits above the word address never reach the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_addr[DATA_W-1:MEM_AW+2], if_req_addr[1:0],
                              d_req_addr[DATA_W-1:MEM_AW+2], d_req_addr[1:0]};

  assign grant_window = rst_n && ((state_reg == IDLE) || (state_reg == RESP));

`ifdef ARB_RR_EN
  req_id_t rr_last_reg, rr_last_next;

  assign rr_last_next = if_acc ? REQ_IF : (d_acc ? REQ_D : rr_last_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) rr_last_reg <= REQ_D;
    else        rr_last_reg <= rr_last_next;
  end
`endif

  mem_arb_pick u_pick (
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
`ifdef ARB_RR_EN
    .rr_last  (rr_last_reg),
`endif
    .window   (grant_window),
    .if_ready (if_req_ready),
    .d_ready  (d_req_ready)
  );

  assign if_acc = if_req_valid && if_req_ready;
  assign d_acc  = d_req_valid && d_req_ready;

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    if_data_next  = if_data_reg;
    d_data_next   = d_data_reg;
    mem_addr_next = mem_addr_reg;
    mem_we        = 1'b0;
    mem_wdata     = '0;

    case (state_reg)
      MEM_WAIT: begin
        if (owner_reg == REQ_IF) if_data_next = mem_rdata;
        else                     d_data_next  = mem_rdata;
        state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // A grant in IDLE or RESP overrides the fall-through to IDLE.
    if (if_acc) begin
      mem_addr_next = if_req_addr[MEM_AW+1:2];
      owner_next    = REQ_IF;
      state_next    = MEM_WAIT;
    end else if (d_acc) begin
      mem_addr_next = d_req_addr[MEM_AW+1:2];
      owner_next    = REQ_D;
      if (d_req_we) begin
        mem_we      = 1'b1;
        mem_wdata   = d_req_wdata;
        d_data_next = '0;
        state_next  = RESP;
      end else begin
        state_next  = MEM_WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      owner_reg    <= REQ_IF;
      if_data_reg  <= '0;
      d_data_reg   <= '0;
      mem_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      if_data_reg  <= if_data_next;
      d_data_reg   <= d_data_next;
      mem_addr_reg <= mem_addr_next;
    end
  end

  assign mem_addr      = mem_addr_next;
  assign if_resp_valid = (state_reg == RESP) && (owner_reg == REQ_IF);
  assign d_resp_valid  = (state_reg == RESP) && (owner_reg == REQ_D);
  assign if_resp_data  = if_data_reg;
  assign d_resp_data   = d_data_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a registered-read memory model.
module tb_mem_port_arbiter;

`ifdef ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0, d_req_valid = 1'b0, d_req_we = 1'b0;
  logic [31:0] if_req_addr = '0, d_req_addr = '0, d_req_wdata = '0;
  logic        if_req_ready, d_req_ready, if_resp_valid, d_resp_valid, mem_we;
  logic [31:0] if_resp_data, d_resp_data, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [5:0]  mem_addr;
  logic        preload = 1'b1;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_model [64];
  logic [31:0] ref_mem [64];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          rr_last_m = 1'b1;   // 1 = D granted last

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_resp_valid (if_resp_valid),
    .if_resp_data  (if_resp_data),
    .d_req_valid   (d_req_valid),
    .d_req_ready   (d_req_ready),
    .d_req_we      (d_req_we),
    .d_req_addr    (d_req_addr),
    .d_req_wdata   (d_req_wdata),
    .d_resp_valid  (d_resp_valid),
    .d_resp_data   (d_resp_data),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'h0050_0093;
    return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= init_word(i);
    end else if (mem_we) begin
      mem_model[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_model[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_resp(input bit is_d, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      check(is_d ? "d_resp_unexpected" : "if_resp_unexpected", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("resp_id", 32'(is_d), 32'(e.is_d));
      check("resp_data", data, e.data);
      check("resp_cycle", 32'(cyc), 32'(e.due));
      $display("resp %s data %h cycle %0d", is_d ? "D " : "IF", data, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (if_resp_valid) check_resp(1'b0, if_resp_data);
    if (d_resp_valid)  check_resp(1'b1, d_resp_data);
  end

  // Waits (bounded) at negedges until either requester sees ready.
  task automatic wait_window(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = if_req_ready || d_req_ready;
      n++;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit track, output int n);
    bit ok;
    logic [5:0] wa;
    wa = addr[7:2];
    if_req_valid = !is_d;
    d_req_valid  = is_d;
    if_req_addr  = addr;
    d_req_addr   = addr;
    d_req_we     = we;
    d_req_wdata  = wdata;
    wait_window(ok, n);
    if (ok) begin
      check(is_d ? "d_ready" : "if_ready", 32'(is_d ? d_req_ready : if_req_ready), 32'd1);
      check("mem_addr", 32'(mem_addr), 32'(wa));
      check("mem_we", 32'(mem_we), 32'(we));
      check("mem_wdata", mem_wdata, we ? wdata : 32'd0);
      if (track) sb.push_back('{is_d, we ? 32'd0 : ref_mem[wa], cyc + (we ? 1 : 2)});
      if (we) ref_mem[wa] = wdata;
      rr_last_m = is_d;
      $display("req %s we %0d addr %h wdata %h accepted cycle %0d",
               is_d ? "D " : "IF", we, addr, wdata, cyc);
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    d_req_we     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  ok;
    bit  exp_d;

    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    // Reset: requests and a store strobe must be suppressed.
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    d_req_we     = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_if_ready", 32'(if_req_ready), 32'd0);
      check("rst_d_ready", 32'(d_req_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
    end
    check("rst_if_resp_valid", 32'(if_resp_valid), 32'd0);
    check("rst_d_resp_valid", 32'(d_resp_valid), 32'd0);
    check("rst_if_resp_data", if_resp_data, 32'd0);
    check("rst_d_resp_data", d_resp_data, 32'd0);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    d_req_we     = 1'b0;
    preload      = 1'b0;
    rst_n        = 1'b1;

    // Single fetch; address holds and no strobe while waiting.
    issue(1'b0, 1'b0, 32'h8, 32'h0, 1'b1, n);
    @(negedge clk);
    check("addr_hold", 32'(mem_addr), 32'd2);
    check("we_idle", 32'(mem_we), 32'd0);
    @(posedge clk); #1;

    // Store then load-back, including a back-to-back store.
    issue(1'b1, 1'b1, 32'h14, 32'hDEAD_BEEF, 1'b1, n);
    issue(1'b1, 1'b1, 32'h18, 32'h0BAD_F00D, 1'b1, n);
    check("store_b2b_wait", 32'(n), 32'd1);
    issue(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, n);
    issue(1'b1, 1'b0, 32'h18, 32'h0, 1'b1, n);

    // Contention: both valid continuously.
    if_req_addr  = 32'h0;
    d_req_addr   = 32'h4;
    d_req_we     = 1'b0;
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_window(ok, n);
      if (ok) begin
        exp_d = RR_MODE ? !rr_last_m : 1'b1;
        check("tie_if_ready", 32'(if_req_ready), 32'(!exp_d));
        check("tie_d_ready", 32'(d_req_ready), 32'(exp_d));
        sb.push_back('{exp_d, exp_d ? ref_mem[1] : ref_mem[0], cyc + 2});
        rr_last_m = exp_d;
        $display("tie grant %s cycle %0d", exp_d ? "D " : "IF", cyc);
      end
      @(posedge clk); #1;
    end
    d_req_valid = 1'b0;
    wait_window(ok, n);
    if (ok) begin
      check("release_if_ready", 32'(if_req_ready), 32'd1);
      check("release_wait", 32'(n), 32'd2);
      sb.push_back('{1'b0, ref_mem[0], cyc + 2});
      rr_last_m = 1'b0;
      $display("release grant IF cycle %0d", cyc);
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0;

    // Address wrap, then reset while a load waits on memory.
    issue(1'b0, 1'b0, 32'h104, 32'h0, 1'b1, n);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, n);
    rst_n       = 1'b0;
    d_req_valid = 1'b1;
    d_req_we    = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midrst_d_ready", 32'(d_req_ready), 32'd0);
      check("midrst_mem_we", 32'(mem_we), 32'd0);
      check("midrst_d_resp_valid", 32'(d_resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    d_req_valid = 1'b0;
    d_req_we    = 1'b0;
    rst_n       = 1'b1;
    rr_last_m   = 1'b1;
    issue(1'b0, 1'b0, 32'h8, 32'h0, 1'b1, n);
    check("idle_after_rst", 32'(n), 32'd1);

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
